timer_seq: RTL and testbench
============================

# timer_seq

Sequencing controller for a WIDTH-stage synchronous load/clear up-counter chain. Each stage loads when LDL is low, clears when CLR is high and toggles when its carry-in is high. The block turns that chain into a programmable interval timer:
- it drives the chain's shared LDL, CLR, load data and stage-0 carry-in (CI);
- it watches the chain's top carry-out (CO);
- it adds prescaling, one-shot/periodic modes and an interrupt flag for the CPU.

## Interface
- WIDTH, 16, counter chain width; reload register width
- PSW, 8, prescaler width
- MasterClock  in  1  sole clock; all flops rising-edge
- RESETL  in  1  asynchronous, active-low reset
- WR  in  1  register write strobe, one cycle per write
- ADDR  in  2  0=RELOAD, 1=CTRL, 2=PRESCALE
- DIN  in  WIDTH  write data
- CO  in  1  chain top carry-out (= CI & all stages at 1), combinational
- LDL  out  1  chain load, active low
- CLR  out  1  chain clear, active high
- CI  out  1  chain count enable (stage-0 carry-in)
- LDVAL  out  WIDTH  chain load data (= RELOAD register)
- IRQ  out  1  terminal-count interrupt, sticky
- OVR  out  1  terminal count while IRQ already set, sticky
- BUSY  out  1  high in LOAD or RUN

## Operation
- CTRL write bits:
  - bit0 START
  - bit1 PERIODIC (stored)
  - bit2 STOP
  - bit3 CLEAR
  - bit4 ACK
- Bits other than PERIODIC are one-shot actions.
- Action priority within one write: CLEAR > STOP > START.
- ACK is independent of the other actions.
- States: IDLE, LOAD, RUN.
- IDLE: LDL=1, CI=0. START -> LOAD.
- LOAD, exactly one cycle: LDL=0, so the chain takes LDVAL at the next edge. Then -> RUN, and the prescale counter PCNT is set to 0.
- RUN:
  - CI=1 in any cycle where PCNT==PRESCALE; PCNT then returns to 0. Otherwise PCNT increments.
  - A terminal tick is CI=1 and CO=1 in the same cycle.
  - On a terminal tick, LDL=0 combinationally in that same cycle, so the chain reloads instead of wrapping to 0.
  - On a terminal tick, IRQ is set. If PERIODIC=0 -> IDLE, otherwise stay in RUN.
- START while in LOAD or RUN restarts: -> LOAD.
- STOP: -> IDLE; the chain holds its value.
- CLEAR: CLR=1 for one cycle, from any state; -> IDLE; the chain becomes 0 at the next edge.
- Period = (PRESCALE+1) * (2^WIDTH - RELOAD) cycles.
- RELOAD=0 gives the full 2^WIDTH ticks.
- IRQ/OVR:
  - A terminal tick with IRQ=1 sets OVR.
  - ACK clears both IRQ and OVR.
  - Terminal tick and ACK in the same cycle: IRQ=1, OVR=0.
- Writes to RELOAD/PRESCALE during RUN take effect at the next load or prescale compare. No hazard handling beyond that.

## Timing
- Reset values:
  - State IDLE; RELOAD=0, PRESCALE=0, PERIODIC=0, PCNT=0.
  - LDL=1, CLR=0, CI=0, IRQ=0, OVR=0, BUSY=0.
- Reset asserted mid-RUN forces these values immediately (asynchronous). The chain keeps its count.
- CLR, CI, BUSY, IRQ and OVR are registered. LDL = registered LOAD term OR'd with the combinational (CI & CO & RUN) term.
- The path CI -> chain CO -> LDL is combinational. It is loop-free because CO does not depend on LDL.
- A START write at edge N: LOAD in cycle N+1, RUN from N+2. The first CI occurs in RUN cycle PRESCALE+1.
- IRQ becomes visible in the cycle after the terminal tick.

## Configuration
- TIMER_SEQ_GATE_EN defined:
  - Adds the input GATE (1 bit).
  - In RUN with GATE=0: PCNT freezes and CI=0.
  - LOAD, CLEAR and STOP are unaffected.
- Undefined: no GATE port; RUN always counts.

## Test plan
- Reset: RESETL low during RUN, with IRQ=1 -> LDL=1, CI=0, CLR=0, IRQ=0, BUSY=0 immediately. After release the block stays IDLE until START.
- One-shot: RELOAD=0xFFFC, PRESCALE=0, CTRL=0x01 -> LDL low for 1 cycle, then CI high for 4 cycles; LDL low in the 4th; IRQ=1 next cycle; BUSY=0; chain reads 0xFFFC.
- Periodic: RELOAD=0xFFFE, PRESCALE=2, CTRL=0x03 -> CI every 3rd cycle; a terminal tick every 6 cycles; no IDLE gap; ACK (0x12) drops IRQ.
- Overflow and ACK collision: periodic with no ACK -> OVR=1 at the 2nd terminal. An ACK coinciding with the 3rd terminal -> IRQ=1, OVR=0.
- CLEAR+START together (CTRL=0x09) mid-RUN -> CLR=1 for one cycle, IDLE, chain=0x0000, no LOAD.
- Gate (with TIMER_SEQ_GATE_EN): GATE=0 for 5 cycles in RUN with PRESCALE=0 -> no CI for those 5 cycles; the terminal tick is delayed by exactly 5 cycles.

Source files
------------

// File: rtl/timer_seq_if.sv
// Bus bundle between the CPU/counter-chain side (master) and the timer_seq controller (slave).
// The GATE signal exists only when TIMER_SEQ_GATE_EN is defined.
interface timer_seq_if #(
    parameter int WIDTH = 16
);
    logic             WR;
    logic [1:0]       ADDR;
    logic [WIDTH-1:0] DIN;
    logic             CO;
    logic             LDL;
    logic             CLR;
    logic             CI;
    logic [WIDTH-1:0] LDVAL;
    logic             IRQ;
    logic             OVR;
    logic             BUSY;
`ifdef TIMER_SEQ_GATE_EN
    logic             GATE;

    modport master (
        output WR, ADDR, DIN, CO, GATE,
        input  LDL, CLR, CI, LDVAL, IRQ, OVR, BUSY
    );

    modport slave (
        input  WR, ADDR, DIN, CO, GATE,
        output LDL, CLR, CI, LDVAL, IRQ, OVR, BUSY
    );
`else
    modport master (
        output WR, ADDR, DIN, CO,
        input  LDL, CLR, CI, LDVAL, IRQ, OVR, BUSY
    );

    modport slave (
        input  WR, ADDR, DIN, CO,
        output LDL, CLR, CI, LDVAL, IRQ, OVR, BUSY
    );
`endif
endinterface

// File: rtl/timer_seq.sv
// Programmable interval timer sequencing an external load/clear up-counter chain.
// Optional feature: define TIMER_SEQ_GATE_EN to add the GATE input (sampled each edge, pauses RUN counting).
module timer_seq #(
    parameter int WIDTH = 16,
    parameter int PSW   = 8
) (
    input  logic        MasterClock,
    input  logic        RESETL,
    timer_seq_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_reload;
    logic [PSW-1:0]   r_prescale;
    logic             r_periodic;
    logic [PSW-1:0]   r_pcnt;
    logic             r_ci;
    logic             r_clr;
    logic             r_load;
    logic             r_busy;
    logic             r_irq;
    logic             r_ovr;

    state_t           w_next_state;
    logic [PSW-1:0]   w_pcnt_next;
    logic             w_ci_next;
    logic             w_ctrl_wr;
    logic             w_start;
    logic             w_stop;
    logic             w_clear;
    logic             w_ack;
    logic             w_tick;
    logic             w_gate_in;
    logic             w_gate_cur;

`ifdef TIMER_SEQ_GATE_EN
    logic             r_gate;

    always_ff @(posedge MasterClock or negedge RESETL) begin
        if (!RESETL) begin
            r_gate <= 1'b1;
        end else begin
            r_gate <= bus.GATE;
        end
    end

    assign w_gate_in  = bus.GATE;
    assign w_gate_cur = r_gate;
`else
    assign w_gate_in  = 1'b1;
    assign w_gate_cur = 1'b1;
`endif

    assign w_ctrl_wr = bus.WR && (bus.ADDR == 2'd1);
    assign w_start   = w_ctrl_wr && bus.DIN[0];
    assign w_stop    = w_ctrl_wr && bus.DIN[2];
    assign w_clear   = w_ctrl_wr && bus.DIN[3];
    assign w_ack     = w_ctrl_wr && bus.DIN[4];

    assign w_tick = (r_state == S_RUN) && r_ci && bus.CO;

    always_ff @(posedge MasterClock or negedge RESETL) begin
        if (!RESETL) begin
            r_reload   <= '0;
            r_prescale <= '0;
            r_periodic <= 1'b0;
        end else if (bus.WR) begin
            unique case (bus.ADDR)
                2'd0:    r_reload   <= bus.DIN;
                2'd1:    r_periodic <= bus.DIN[1];
                2'd2:    r_prescale <= bus.DIN[PSW-1:0];
                default: ;
            endcase
        end
    end

    // CI is a registered output, so the prescale compare is evaluated one cycle
    // ahead against the PCNT value the next cycle will hold.
    always_comb begin
        w_next_state = r_state;
        w_pcnt_next  = r_pcnt;
        unique case (r_state)
            S_IDLE: ;
            S_LOAD: begin
                w_next_state = S_RUN;
                w_pcnt_next  = '0;
            end
            S_RUN: begin
                if (r_ci) begin
                    w_pcnt_next = '0;
                end else if (w_gate_cur) begin
                    w_pcnt_next = r_pcnt + PSW'(1);
                end
                if (w_tick && !r_periodic) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
        if (w_clear || w_stop) begin
            w_next_state = S_IDLE;
        end else if (w_start) begin
            w_next_state = S_LOAD;
        end
        w_ci_next = (w_next_state == S_RUN) && (w_pcnt_next == r_prescale) && w_gate_in;
    end

    always_ff @(posedge MasterClock or negedge RESETL) begin
        if (!RESETL) begin
            r_state <= S_IDLE;
            r_pcnt  <= '0;
            r_ci    <= 1'b0;
            r_clr   <= 1'b0;
            r_load  <= 1'b0;
            r_busy  <= 1'b0;
            r_irq   <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_pcnt  <= w_pcnt_next;
            r_ci    <= w_ci_next;
            r_clr   <= w_clear;
            r_load  <= (w_next_state == S_LOAD);
            r_busy  <= (w_next_state != S_IDLE);
            r_irq   <= w_tick || (r_irq && !w_ack);
            r_ovr   <= !w_ack && (r_ovr || (w_tick && r_irq));
        end
    end

    // The terminal-tick reload must reach the chain in the same cycle, hence the combinational OR.
    assign bus.LDL   = !(r_load || w_tick);
    assign bus.CLR   = r_clr;
    assign bus.CI    = r_ci;
    assign bus.LDVAL = r_reload;
    assign bus.IRQ   = r_irq;
    assign bus.OVR   = r_ovr;
    assign bus.BUSY  = r_busy;

endmodule

// File: tb/tb_timer_seq.sv
// Directed testbench for timer_seq with a behavioural 16-bit counter chain attached.
// The gate scenario runs only when TIMER_SEQ_GATE_EN is defined.
module tb_timer_seq;

    logic        clk = 1'b0;
    logic        rstN;
    logic [15:0] chain = 16'h0000;
    int          testsRun = 0;
    int          testsFailed = 0;

    timer_seq_if #(.WIDTH(16)) bus();

    timer_seq #(.WIDTH(16), .PSW(8)) dut (
        .MasterClock (clk),
        .RESETL      (rstN),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    // Chain model: clear beats load beats count; CO is the combinational top carry.
    assign bus.CO = bus.CI & (&chain);

    always @(posedge clk) begin
        if (bus.CLR)
            chain <= 16'h0000;
        else if (!bus.LDL)
            chain <= bus.LDVAL;
        else if (bus.CI)
            chain <= chain + 16'h0001;
    end

    // Observed vector: {LDL, CLR, CI, BUSY, IRQ, OVR}
    wire [5:0] obs = {bus.LDL, bus.CLR, bus.CI, bus.BUSY, bus.IRQ, bus.OVR};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] addr, input logic [15:0] data);
        bus.WR   = 1'b1;
        bus.ADDR = addr;
        bus.DIN  = data;
        step();
        bus.WR   = 1'b0;
    endtask

    task automatic test_reset();
        step();
        testsRun++;
        if (obs !== 6'b100000) begin
            testsFailed++;
            $display("[TB] FAIL reset_outputs: got %b expected %b", obs, 6'b100000);
        end
        testsRun++;
        if (bus.LDVAL !== 16'h0000) begin
            testsFailed++;
            $display("[TB] FAIL reset_ldval: got %h expected %h", bus.LDVAL, 16'h0000);
        end
        rstN = 1'b1;
        step();
        step();
        testsRun++;
        if (obs !== 6'b100000) begin
            testsFailed++;
            $display("[TB] FAIL reset_idle_after_release: got %b expected %b", obs, 6'b100000);
        end
    endtask

    task automatic test_one_shot();
        logic [5:0] exp;
        applyStimulus(2'd0, 16'hFFFC);
        applyStimulus(2'd2, 16'h0000);
        applyStimulus(2'd1, 16'h0001);
        testsRun++;
        if (obs !== 6'b000100) begin
            testsFailed++;
            $display("[TB] FAIL oneshot_load: got %b expected %b", obs, 6'b000100);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            exp = (i == 3) ? 6'b001100 : 6'b101100;
            testsRun++;
            if (obs !== exp) begin
                testsFailed++;
                $display("[TB] FAIL oneshot_run_%0d: got %b expected %b", i, obs, exp);
            end
            testsRun++;
            if (chain !== 16'hFFFC + 16'(i)) begin
                testsFailed++;
                $display("[TB] FAIL oneshot_chain_%0d: got %h expected %h", i, chain, 16'hFFFC + 16'(i));
            end
        end
        step();
        testsRun++;
        if (obs !== 6'b100010) begin
            testsFailed++;
            $display("[TB] FAIL oneshot_done: got %b expected %b", obs, 6'b100010);
        end
        testsRun++;
        if (chain !== 16'hFFFC) begin
            testsFailed++;
            $display("[TB] FAIL oneshot_reloaded: got %h expected %h", chain, 16'hFFFC);
        end
    endtask

    task automatic test_periodic();
        logic [5:0] exp;
        applyStimulus(2'd1, 16'h0010);
        testsRun++;
        if (obs !== 6'b100000) begin
            testsFailed++;
            $display("[TB] FAIL ack_idle: got %b expected %b", obs, 6'b100000);
        end
        applyStimulus(2'd0, 16'hFFFE);
        applyStimulus(2'd2, 16'h0002);
        applyStimulus(2'd1, 16'h0003);
        testsRun++;
        if (obs !== 6'b000100) begin
            testsFailed++;
            $display("[TB] FAIL periodic_load: got %b expected %b", obs, 6'b000100);
        end
        for (int r = 1; r <= 6; r++) begin
            step();
            exp = {r != 6, 1'b0, (r % 3) == 0, 1'b1, 1'b0, 1'b0};
            testsRun++;
            if (obs !== exp) begin
                testsFailed++;
                $display("[TB] FAIL periodic_run_%0d: got %b expected %b", r, obs, exp);
            end
        end
        step();
        testsRun++;
        if (obs !== 6'b100110) begin
            testsFailed++;
            $display("[TB] FAIL periodic_irq: got %b expected %b", obs, 6'b100110);
        end
        testsRun++;
        if (chain !== 16'hFFFE) begin
            testsFailed++;
            $display("[TB] FAIL periodic_reload: got %h expected %h", chain, 16'hFFFE);
        end
        applyStimulus(2'd1, 16'h0012);
        testsRun++;
        if (obs !== 6'b100100) begin
            testsFailed++;
            $display("[TB] FAIL periodic_ack: got %b expected %b", obs, 6'b100100);
        end
    endtask

    task automatic test_overflow_ack();
        applyStimulus(2'd1, 16'h0013);
        testsRun++;
        if (obs !== 6'b000100) begin
            testsFailed++;
            $display("[TB] FAIL ovr_load: got %b expected %b", obs, 6'b000100);
        end
        for (int r = 1; r <= 18; r++) begin
            step();
            if (r == 7) begin
                testsRun++;
                if (obs !== 6'b100110) begin
                    testsFailed++;
                    $display("[TB] FAIL ovr_first_irq: got %b expected %b", obs, 6'b100110);
                end
            end
            if (r == 12) begin
                testsRun++;
                if (obs !== 6'b001110) begin
                    testsFailed++;
                    $display("[TB] FAIL ovr_second_tick: got %b expected %b", obs, 6'b001110);
                end
            end
            if (r == 13) begin
                testsRun++;
                if (obs !== 6'b100111) begin
                    testsFailed++;
                    $display("[TB] FAIL ovr_set: got %b expected %b", obs, 6'b100111);
                end
            end
        end
        testsRun++;
        if (obs !== 6'b001111) begin
            testsFailed++;
            $display("[TB] FAIL ovr_third_tick: got %b expected %b", obs, 6'b001111);
        end
        applyStimulus(2'd1, 16'h0012);
        testsRun++;
        if (obs !== 6'b100110) begin
            testsFailed++;
            $display("[TB] FAIL ovr_ack_collision: got %b expected %b", obs, 6'b100110);
        end
    endtask

    task automatic test_clear_start();
        applyStimulus(2'd1, 16'h0009);
        testsRun++;
        if (obs !== 6'b110010) begin
            testsFailed++;
            $display("[TB] FAIL clear_pulse: got %b expected %b", obs, 6'b110010);
        end
        step();
        testsRun++;
        if (obs !== 6'b100010) begin
            testsFailed++;
            $display("[TB] FAIL clear_single_cycle: got %b expected %b", obs, 6'b100010);
        end
        testsRun++;
        if (chain !== 16'h0000) begin
            testsFailed++;
            $display("[TB] FAIL clear_chain: got %h expected %h", chain, 16'h0000);
        end
        repeat (3) step();
        testsRun++;
        if ({obs, chain} !== {6'b100010, 16'h0000}) begin
            testsFailed++;
            $display("[TB] FAIL clear_no_load: got %b/%h expected %b/%h", obs, chain, 6'b100010, 16'h0000);
        end
    endtask

    task automatic test_reset_mid_run();
        applyStimulus(2'd1, 16'h0001);
        repeat (3) step();
        testsRun++;
        if (obs !== 6'b101110) begin
            testsFailed++;
            $display("[TB] FAIL midrun_before_reset: got %b expected %b", obs, 6'b101110);
        end
        rstN = 1'b0;
        #1;
        testsRun++;
        if (obs !== 6'b100000) begin
            testsFailed++;
            $display("[TB] FAIL midrun_async_reset: got %b expected %b", obs, 6'b100000);
        end
        step();
        testsRun++;
        if (chain !== 16'hFFFE) begin
            testsFailed++;
            $display("[TB] FAIL midrun_chain_kept: got %h expected %h", chain, 16'hFFFE);
        end
        rstN = 1'b1;
        repeat (3) step();
        testsRun++;
        if ({obs, bus.LDVAL} !== {6'b100000, 16'h0000}) begin
            testsFailed++;
            $display("[TB] FAIL midrun_idle_after: got %b/%h expected %b/%h", obs, bus.LDVAL, 6'b100000, 16'h0000);
        end
    endtask

`ifdef TIMER_SEQ_GATE_EN
    task automatic test_gate();
        logic [5:0] exp;
        applyStimulus(2'd0, 16'hFFFC);
        applyStimulus(2'd1, 16'h0001);
        bus.GATE = 1'b0;
        for (int r = 1; r <= 9; r++) begin
            step();
            if (r <= 5)
                exp = 6'b100100;
            else if (r < 9)
                exp = 6'b101100;
            else
                exp = 6'b001100;
            testsRun++;
            if (obs !== exp) begin
                testsFailed++;
                $display("[TB] FAIL gate_run_%0d: got %b expected %b", r, obs, exp);
            end
            if (r == 5)
                bus.GATE = 1'b1;
        end
        step();
        testsRun++;
        if (obs !== 6'b100010) begin
            testsFailed++;
            $display("[TB] FAIL gate_done: got %b expected %b", obs, 6'b100010);
        end
    endtask
`endif

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rstN     = 1'b0;
        bus.WR   = 1'b0;
        bus.ADDR = 2'd0;
        bus.DIN  = 16'h0000;
`ifdef TIMER_SEQ_GATE_EN
        bus.GATE = 1'b1;
`endif
        test_reset();
        test_one_shot();
        test_periodic();
        test_overflow_ack();
        test_clear_start();
        test_reset_mid_run();
`ifdef TIMER_SEQ_GATE_EN
        test_gate();
`endif
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
